// File: rtl/pulse_train_gen_if.sv
// Trigger/config and status bundle for pulse_train_gen.
// The master drives the trigger and config; the slave (the generator) returns the pulse status.
interface pulse_train_gen_if #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned BURST_W = 8
);
  logic               trigger;
  logic [1:0]         mode;
  logic [CNT_W-1:0]   high_cycles;
  logic [CNT_W-1:0]   low_cycles;
  logic [BURST_W-1:0] burst_count;
  logic               abort;
  logic               pulse_out;
  logic               busy;
  logic               done;
  logic [BURST_W-1:0] pulse_idx;

  modport master (
    output trigger, mode, high_cycles, low_cycles, burst_count, abort,
    input  pulse_out, busy, done, pulse_idx
  );

  modport slave (
    input  trigger, mode, high_cycles, low_cycles, burst_count, abort,
    output pulse_out, busy, done, pulse_idx
  );
endinterface

// File: rtl/pulse_train_gen.sv
// Trigger-launched pulse generator: one-shot, counted burst or continuous train.
// Trigger is synchronised and edge-detected; the config is latched at start.
module pulse_train_gen #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned BURST_W     = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic              clk,
  input logic              rst_n,
  pulse_train_gen_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

  localparam logic [1:0] ModeBurst = 2'd1;
  localparam logic [1:0] ModeCont  = 2'd2;

  state_e               state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 hist_q;
  logic                 trig_edge;
  logic [1:0]           mode_q, mode_d;
  logic [CNT_W-1:0]     high_q, high_d, low_q, low_d, cnt_q, cnt_d;
  logic [BURST_W-1:0]   burst_q, burst_d, idx_q, idx_d;
  logic                 pulse_q, pulse_d, busy_q, busy_d, done_q, done_d;
  logic [CNT_W-1:0]     high_in, low_in;
  logic [BURST_W-1:0]   burst_in;

  assign trig_edge = sync_q[SYNC_STAGES-1] & ~hist_q;

  // A zero period or count would stall the counters, so it is run as one.
  assign high_in  = (bus.high_cycles == '0) ? CNT_W'(1) : bus.high_cycles;
  assign low_in   = (bus.low_cycles == '0) ? CNT_W'(1) : bus.low_cycles;
  assign burst_in = (bus.burst_count == '0) ? BURST_W'(1) : bus.burst_count;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    high_d  = high_q;
    low_d   = low_q;
    burst_d = burst_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (trig_edge && !bus.abort) begin
          state_d = StHigh;
          mode_d  = bus.mode;
          high_d  = high_in;
          low_d   = low_in;
          burst_d = burst_in;
          cnt_d   = high_in - CNT_W'(1);
          idx_d   = '0;
        end
      end
      StHigh: begin
        if (bus.abort) begin
          state_d = StIdle;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if ((mode_q == ModeCont) ||
                     ((mode_q == ModeBurst) && (idx_q != burst_q - BURST_W'(1)))) begin
          state_d = StLow;
          cnt_d   = low_q - CNT_W'(1);
        end else begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      StLow: begin
        if (bus.abort) begin
          state_d = StIdle;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = StHigh;
          cnt_d   = high_q - CNT_W'(1);
          idx_d   = idx_q + BURST_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    pulse_d = (state_d == StHigh);
    busy_d  = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      hist_q  <= 1'b0;
      state_q <= StIdle;
      mode_q  <= '0;
      high_q  <= '0;
      low_q   <= '0;
      burst_q <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.trigger};
      hist_q  <= sync_q[SYNC_STAGES-1];
      state_q <= state_d;
      mode_q  <= mode_d;
      high_q  <= high_d;
      low_q   <= low_d;
      burst_q <= burst_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.pulse_out = pulse_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pulse_idx = idx_q;

endmodule
